// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: groups the control inputs and registered outputs of lfsr_gen.
//   en, load, seed_in      : driven by the consumer (master) into the LFSR.
//   data_out, bit_out      : current register contents and its MSB.
//   wrap, seed_err         : one-cycle status pulses from the LFSR.
// The master modport is for the user of the generator, and the slave modport is
// for lfsr_gen itself.
interface lfsr_gen_if #(
  parameter int DATA_W = 8
);
  logic              en;
  logic              load;
  logic [DATA_W-1:0] seed_in;
  logic [DATA_W-1:0] data_out;
  logic              bit_out;
  logic              wrap;
  logic              seed_err;

  modport master (
    output en, load, seed_in,
    input  data_out, bit_out, wrap, seed_err
  );

  modport slave (
    input  en, load, seed_in,
    output data_out, bit_out, wrap, seed_err
  );
endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with seed loading and a period-wrap flag.
//   clk          : rising-edge clock.
//   rst          : asynchronous active-high reset; register returns to SEED.
//   bus.en       : advance the register by STEPS shifts this cycle.
//   bus.load     : load bus.seed_in (priority over en); a zero seed loads SEED instead.
//   bus.data_out : register contents.
//   bus.bit_out  : register MSB (serial output).
//   bus.wrap     : pulse after an en update that lands back on SEED.
//   bus.seed_err : pulse after a load attempted with an all-zero seed.
// All outputs come straight from flops, so no input reaches an output combinationally.
module lfsr_gen #(
  parameter int                WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0]  SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int                STEPS = 1
) (
  input logic         clk,
  input logic         rst,
  lfsr_gen_if.slave   bus
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_gen: WIDTH must lie in 2..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be non-zero");
  end
  if (TAPS == '0) begin : g_bad_taps
    $error("lfsr_gen: TAPS must be non-zero");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_gen: STEPS must lie in 1..WIDTH");
  end

  // One Fibonacci shift: the tapped bits XOR into the new LSB.
  function automatic logic [WIDTH-1:0] lfsr_shift(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  // STEPS shifts are chained combinationally so that only the final state is committed.
  function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    r = s;
    for (int i = 0; i < STEPS; i++) begin
      r = lfsr_shift(r);
    end
    return r;
  endfunction

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             wrap_q, wrap_d;
  logic             seed_err_q, seed_err_d;
  logic [WIDTH-1:0] adv;

  always_comb begin
    sreg_d     = sreg_q;
    wrap_d     = 1'b0;
    seed_err_d = 1'b0;
    adv        = lfsr_advance(sreg_q);
    if (bus.load) begin
      // A zero seed would lock the register up, so recover to SEED and flag it.
      if (bus.seed_in != '0) begin
        sreg_d = bus.seed_in;
      end else begin
        sreg_d     = SEED;
        seed_err_d = 1'b1;
      end
    end else if (bus.en) begin
      sreg_d = adv;
      wrap_d = (adv == SEED);
    end
  end

  // State register boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q     <= SEED;
      wrap_q     <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      sreg_q     <= sreg_d;
      wrap_q     <= wrap_d;
      seed_err_q <= seed_err_d;
    end
  end

  assign bus.data_out = sreg_q;
  assign bus.bit_out  = sreg_q[WIDTH-1];
  assign bus.wrap     = wrap_q;
  assign bus.seed_err = seed_err_q;

endmodule

// File: tb/tb_lfsr_gen.sv
module tb_lfsr_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // A: WIDTH=4 TAPS=1100 SEED=1 STEPS=1; B: defaults; C: as A with STEPS=2.
  lfsr_gen_if #(.DATA_W(4)) ia ();
  lfsr_gen_if #(.DATA_W(8)) ib ();
  lfsr_gen_if #(.DATA_W(4)) ic ();

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'd1), .STEPS(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  lfsr_gen                                                      dut_b (.clk(clk), .rst(rst), .bus(ib));
  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'd1), .STEPS(2)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  int checks   = 0;
  int failures = 0;

  // Reference model state and expected pulses per DUT.
  int ma, mb, mc;
  bit wa, wb, wc, ea, eb, ec;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference: the feedback bit is the parity of the tapped bits,
  // and a shift is doubling modulo 2^w plus that parity.
  function automatic void ref_apply(input int st, input logic en, input logic ld, input int sin,
                                    input int w, input int taps, input int seedv, input int steps,
                                    output int nst, output bit wr, output bit er);
    nst = st; wr = 0; er = 0;
    if (ld) begin
      if (sin != 0) nst = sin;
      else begin nst = seedv; er = 1; end
    end else if (en) begin
      for (int k = 0; k < steps; k++)
        nst = ((nst * 2) + ($countones(nst & taps) % 2)) % (1 << w);
      wr = (nst == seedv);
    end
  endfunction

  task automatic chk_dut(input string nm, input int m, input bit w, input bit e, input int width,
                         input logic [31:0] d, input logic b, input logic wr, input logic er);
    check({nm, ".data"}, d, m);
    check({nm, ".bit"}, {31'd0, b}, (m >> (width - 1)) & 1);
    check({nm, ".wrap"}, {31'd0, wr}, {31'd0, w});
    check({nm, ".seed_err"}, {31'd0, er}, {31'd0, e});
  endtask

  task automatic chk_all();
    chk_dut("A", ma, wa, ea, 4, {28'd0, ia.data_out}, ia.bit_out, ia.wrap, ia.seed_err);
    chk_dut("B", mb, wb, eb, 8, {24'd0, ib.data_out}, ib.bit_out, ib.wrap, ib.seed_err);
    chk_dut("C", mc, wc, ec, 4, {28'd0, ic.data_out}, ic.bit_out, ic.wrap, ic.seed_err);
  endtask

  task automatic model_reset();
    ma = 1; mb = 1; mc = 1;
    wa = 0; wb = 0; wc = 0; ea = 0; eb = 0; ec = 0;
  endtask

  // One clock: predict from current inputs, advance, sample 1 time unit after the edge.
  task automatic tick();
    int na, nb, nc;
    ref_apply(ma, ia.en, ia.load, int'(ia.seed_in), 4, 'hC,  1, 1, na, wa, ea);
    ref_apply(mb, ib.en, ib.load, int'(ib.seed_in), 8, 'hB8, 1, 1, nb, wb, eb);
    ref_apply(mc, ic.en, ic.load, int'(ic.seed_in), 4, 'hC,  1, 2, nc, wc, ec);
    @(posedge clk); #1;
    ma = na; mb = nb; mc = nc;
    chk_all();
  endtask

  task automatic drive_all(input logic en, input logic ld);
    ia.en = en; ib.en = en; ic.en = en;
    ia.load = ld; ib.load = ld; ic.load = ld;
  endtask

  typedef struct {
    logic       en;
    logic       ld;
    logic [3:0] sin;
    logic [3:0] exp_d;
    logic       exp_w;
    logic       exp_e;
  } vec_t;

  vec_t vtab[15];
  logic [3:0] seq_c[5];
  int b_cycle;
  int b_wraps[$];
  bit seen[256];
  int distinct;
  logic [3:0] held;

  initial begin
    logic [3:0] seq_a[15];
    seq_a = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101,
              4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
    for (int i = 0; i < 15; i++)
      vtab[i] = '{en: 1'b1, ld: 1'b0, sin: 4'd0, exp_d: seq_a[i], exp_w: (i == 14), exp_e: 1'b0};
    seq_c = '{4'b0100, 4'b0011, 4'b1101, 4'b0101, 4'b0111};

    rst = 1'b1;
    drive_all(1'b0, 1'b0);
    ia.seed_in = '0; ib.seed_in = '0; ic.seed_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    rst = 1'b0;

    // Free-running from reset: table-driven on A, hand sequence on C, period on B.
    b_cycle = 0;
    for (int i = 0; i < 15; i++) begin
      ia.en = vtab[i].en; ia.load = vtab[i].ld; ia.seed_in = vtab[i].sin;
      ib.en = 1'b1; ic.en = 1'b1;
      tick();
      b_cycle++;
      check("tabA.data", {28'd0, ia.data_out}, {28'd0, vtab[i].exp_d});
      check("tabA.wrap", {31'd0, ia.wrap}, {31'd0, vtab[i].exp_w});
      check("tabA.err", {31'd0, ia.seed_err}, {31'd0, vtab[i].exp_e});
      check("tabA.bit", {31'd0, ia.bit_out}, {31'd0, vtab[i].exp_d[3]});
      if (i < 5) check("seqC.data", {28'd0, ic.data_out}, {28'd0, seq_c[i]});
      check("seqC.wrap", {31'd0, ic.wrap}, {31'd0, (i == 14)});
      if (ib.wrap) b_wraps.push_back(b_cycle);
      if (b_cycle <= 255) seen[ib.data_out] = 1'b1;
    end
    for (int i = 15; i < 600; i++) begin
      tick();
      b_cycle++;
      if (ib.wrap) b_wraps.push_back(b_cycle);
      if (b_cycle <= 255) seen[ib.data_out] = 1'b1;
      if (ib.data_out == 8'd0) check("B.nonzero", {24'd0, ib.data_out}, 32'd1);
    end
    check("B.wrap_count", b_wraps.size(), 2);
    if (b_wraps.size() == 2) begin
      check("B.wrap_first", b_wraps[0], 255);
      check("B.wrap_second", b_wraps[1], 510);
    end
    distinct = 0;
    for (int v = 0; v < 256; v++) if (seen[v]) distinct++;
    check("B.distinct", distinct, 255);
    check("B.zero_seen", {31'd0, seen[0]}, 0);

    // Hold for 10 cycles.
    drive_all(1'b0, 1'b0);
    held = ia.data_out;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold.data", {28'd0, ia.data_out}, {28'd0, held});
      check("hold.wrap", {31'd0, ia.wrap}, 0);
    end

    // load wins over en, then stepping continues from the loaded value.
    drive_all(1'b1, 1'b1);
    ia.seed_in = 4'b1010; ib.seed_in = 8'h5A; ic.seed_in = 4'b1010;
    tick();
    check("load.data", {28'd0, ia.data_out}, 32'hA);
    check("load.wrap", {31'd0, ia.wrap}, 0);
    drive_all(1'b1, 1'b0);
    tick();
    check("load.next", {28'd0, ia.data_out}, 32'h5);

    // Zero-seed load substitutes SEED and pulses seed_err once.
    drive_all(1'b0, 1'b1);
    ia.seed_in = '0; ib.seed_in = '0; ic.seed_in = '0;
    tick();
    check("zload.data", {28'd0, ia.data_out}, 32'h1);
    check("zload.err", {31'd0, ia.seed_err}, 1);
    drive_all(1'b0, 1'b0);
    tick();
    check("zload.err_clear", {31'd0, ia.seed_err}, 0);

    // Loading a value equal to SEED is not a wrap.
    drive_all(1'b0, 1'b1);
    ia.seed_in = 4'd1; ib.seed_in = 8'd1; ic.seed_in = 4'd1;
    tick();
    check("sload.wrap", {31'd0, ia.wrap}, 0);

    // Randomized mixed traffic against the model.
    for (int i = 0; i < 400; i++) begin
      ia.en = 1'($urandom_range(0, 3) != 0);
      ib.en = 1'($urandom_range(0, 3) != 0);
      ic.en = 1'($urandom_range(0, 3) != 0);
      ia.load = 1'($urandom_range(0, 7) == 0);
      ib.load = 1'($urandom_range(0, 7) == 0);
      ic.load = 1'($urandom_range(0, 7) == 0);
      ia.seed_in = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      ib.seed_in = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      ic.seed_in = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      tick();
    end

    // Asynchronous reset mid-cycle, then first advance after release.
    drive_all(1'b0, 1'b1);
    ia.seed_in = 4'b1010; ib.seed_in = 8'hC3; ic.seed_in = 4'b0110;
    tick();
    drive_all(1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_all();
    check("areset.data", {28'd0, ia.data_out}, 32'h1);
    @(posedge clk); #1;
    chk_all();
    rst = 1'b0;
    drive_all(1'b1, 1'b0);
    tick();
    check("release.first", {28'd0, ia.data_out}, 32'h2);
    check("release.firstC", {28'd0, ic.data_out}, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci linear-feedback shift register: the generalised pseudo-random source for lab designs such as reaction timers, random delays and test-pattern generation. Width, tap polynomial, reset seed and steps-per-enable are set at elaboration. Adds synchronous seed loading with zero-seed protection and a period-wrap indicator. All outputs are registered and sit directly on the FSM-side datapath.

## Interface
- WIDTH, 8, register width in bits; legal range 2..32.
- TAPS, 8'hB8, WIDTH-bit feedback mask; bit i set means sreg[i] feeds the XOR.
- SEED, 1, WIDTH-bit reset and recovery value; must be non-zero.
- STEPS, 1, LFSR shifts applied per enabled cycle; legal range 1..WIDTH.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  advance the register by STEPS shifts this cycle.
- load  in  1  load seed_in this cycle; has priority over en.
- seed_in  in  WIDTH  value to load when load=1.
- data_out  out  WIDTH  current register contents (sreg).
- bit_out  out  1  serial output, equal to sreg[WIDTH-1].
- wrap  out  1  one-cycle pulse: an en update has just returned sreg to SEED.
- seed_err  out  1  one-cycle pulse: a load was attempted with seed_in all-zero.

## Operation
- Single shift: next = XOR-reduce(sreg AND TAPS); sreg becomes {sreg[WIDTH-2:0], next}.
- STEPS shifts are composed combinationally and committed in one edge. No intermediate states are visible.
- Priority per rising edge:
  - rst: highest, asynchronous.
  - load: if seed_in != 0, sreg <= seed_in; if seed_in == 0, sreg <= SEED and seed_err <= 1.
  - en: sreg <= result of STEPS shifts.
  - else: hold.
- wrap <= 1 only on an en update whose result equals SEED. It is 0 on load, hold and reset cycles, and 0 when a load happens to equal SEED.
- seed_err is 0 on every cycle except the one following a zero-seed load.
- The register never enters the all-zero state:
  - reset gives SEED;
  - a zero load is substituted with SEED;
  - a non-zero state cannot map to zero through XOR feedback.
- Reset values:
  - data_out = SEED;
  - bit_out = SEED[WIDTH-1];
  - wrap = 0;
  - seed_err = 0.
- Reset mid-operation forces all outputs to their reset values immediately, with no wait for clk.
- Elaboration checks fail compilation for any of: SEED == 0, TAPS == 0, STEPS outside 1..WIDTH, WIDTH outside 2..32.

## Timing
- Latency: en, load or seed_in sampled at edge N is reflected on data_out, bit_out, wrap and seed_err after edge N.
- No combinational path from any input to any output.
- en held high: one new STEPS-advanced value per cycle, no bubbles.
- load and en high together: the load wins and en is ignored for that cycle. The next cycle with en=1 steps from the loaded value.
- Reset release: the first edge with rst=0 and en=1 produces the first advanced value.
- Period is (2^WIDTH - 1) shifts for primitive TAPS. wrap asserts every P/gcd(P, STEPS) enabled cycles, where P is the period.

## Test plan
- Reset, WIDTH=4, TAPS=4'b1100, SEED=1: assert rst mid-run with no clock edge. Required: data_out=4'b0001, wrap=0, seed_err=0 immediately.
- Same configuration, en=1 continuously from reset. Required:
  - data_out sequence 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, 0001;
  - wrap pulses only in the cycle showing 0001 (15th update);
  - bit_out tracks data_out[3].
- Default parameters, en=1 for 600 cycles. Required:
  - wrap pulses at cycles 255 and 510 only;
  - data_out is never 0;
  - all 255 non-zero values appear once per period.
- STEPS=2 at WIDTH=4 config, en=1 from reset. Required:
  - data_out sequence 0100, 0011, 1101, 0101, 0111, ...;
  - first wrap on cycle 15.
- Load behaviour:
  - load=1 with seed_in=4'b1010 and en=1 in the same cycle: data_out=1010 next cycle, no wrap; the following en gives 0101.
  - load=1 with seed_in=0: data_out=0001 and seed_err=1 for exactly one cycle.
- Hold: en=0, load=0 for 10 cycles mid-sequence. Required: data_out is unchanged and wrap=0 throughout.
